mult_error_accumulator: RTL

- Downstream consumer of an M x N multiplier under evaluation (exact or approximate).
- Takes operand pairs plus the DUT product over a valid/ready stream.
- Recomputes the exact product internally and accumulates error statistics over a programmed sample count: mismatches, sum of absolute error, and maximum absolute error with the operands that caused it.
- Gives a hardware error-metric path for NSGA-generated multipliers, so exhaustive sweeps run on-chip instead of in the simulator.

---
 rtl/mult_err_pkg.sv | 34 +++
 rtl/mult_abs_err.sv | 29 ++
 rtl/mult_error_accumulator.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/mult_err_pkg.sv
// Shared types, default widths and arithmetic helpers for the multiplier error accumulator.
package mult_err_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DEF_M = 8;
    localparam int DEF_N = 8;

    // One extra bit so an exhaustive sweep of 2^(M+N) samples is representable.
    function automatic int cnt_w(input int m, input int n);
        return m + n + 1;
    endfunction

    function automatic int sum_w(input int m, input int n);
        return 2 * (m + n) + 1;
    endfunction

    // Unsigned add clamped to max_val; callers zero-extend operands to 64 bits.
    function automatic logic [63:0] sat_add(input logic [63:0] acc,
                                            input logic [63:0] inc,
                                            input logic [63:0] max_val);
        logic [64:0] s;
        s = {1'b0, acc} + {1'b0, inc};
        if (s > {1'b0, max_val})
            return max_val;
        return s[63:0];
    endfunction

endpackage

// File: rtl/mult_abs_err.sv
// Exact unsigned product and |prod - a*b|; the error sign is exported when MULT_ERR_BIAS_EN is defined.
module mult_abs_err #(
    parameter int M   = 8,
    parameter int N   = 8,
    parameter int P_W = M + N
) (
    input  logic [M-1:0]   a,
    input  logic [N-1:0]   b,
    input  logic [P_W-1:0] prod,
    output logic [P_W-1:0] abs_err
`ifdef MULT_ERR_BIAS_EN
    ,
    output logic           neg
`endif
);

    logic [P_W-1:0] exact;
    logic [P_W:0]   diff;

    assign exact = P_W'(a) * P_W'(b);
    // One guard bit so the borrow tells which operand is larger.
    assign diff    = {1'b0, prod} - {1'b0, exact};
    assign abs_err = diff[P_W] ? (exact - prod) : diff[P_W-1:0];

`ifdef MULT_ERR_BIAS_EN
    assign neg = diff[P_W];
`endif

endmodule

// File: rtl/mult_error_accumulator.sv
// Error-statistics accumulator for a multiplier under test: two-stage pipeline plus run control.
// Optional signed-bias output is enabled by defining MULT_ERR_BIAS_EN.
module mult_error_accumulator
    import mult_err_pkg::*;
#(
    parameter int M     = DEF_M,
    parameter int N     = DEF_N,
    parameter int P_W   = M + N,
    parameter int CNT_W = cnt_w(M, N),
    parameter int SUM_W = sum_w(M, N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_samples,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [M-1:0]     in_a,
    input  logic [N-1:0]     in_b,
    input  logic [P_W-1:0]   in_prod,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] total_cnt,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic [SUM_W-1:0] sum_abs_err,
    output logic [P_W-1:0]   max_abs_err,
    output logic [M-1:0]     max_err_a,
    output logic [N-1:0]     max_err_b
`ifdef MULT_ERR_BIAS_EN
    ,
    output logic signed [SUM_W:0] sum_signed_err
`endif
);

    localparam logic [63:0] SUM_MAX = {{(64-SUM_W){1'b0}}, {SUM_W{1'b1}}};

    state_t           state_reg, state_next;
    logic             start_accept;
    logic             transfer;
    logic [CNT_W-1:0] target_reg, accepted_reg;

    logic             s1_valid_reg;
    logic [M-1:0]     s1_a_reg;
    logic [N-1:0]     s1_b_reg;
    logic [P_W-1:0]   s1_abs_reg;
    logic [P_W-1:0]   abs_err_w;

    logic             s2_valid_reg;
    logic [CNT_W-1:0] total_reg, mismatch_reg;
    logic [SUM_W-1:0] sum_abs_reg;
    logic [P_W-1:0]   max_err_reg;
    logic [M-1:0]     max_a_reg;
    logic [N-1:0]     max_b_reg;

    assign in_ready = (state_reg == RUN) && (accepted_reg < target_reg);
    assign transfer = in_valid && in_ready;
    assign busy     = (state_reg == RUN) || (state_reg == DRAIN);
    assign done     = (state_reg == DONE);

    always_comb begin
        state_next   = state_reg;
        start_accept = 1'b0;
        case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    start_accept = 1'b1;
                    state_next   = (num_samples == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (transfer && (accepted_reg + CNT_W'(1) == target_reg))
                    state_next = DRAIN;
            end
            DRAIN: begin
                if (!s1_valid_reg && !s2_valid_reg)
                    state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            target_reg   <= '0;
            accepted_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (start_accept) begin
                target_reg   <= num_samples;
                accepted_reg <= '0;
            end else if (transfer) begin
                accepted_reg <= accepted_reg + CNT_W'(1);
            end
        end
    end

`ifdef MULT_ERR_BIAS_EN
    logic neg_w;
    logic s1_neg_reg;
`endif

    mult_abs_err #(.M(M), .N(N), .P_W(P_W)) u_abs (
        .a       (in_a),
        .b       (in_b),
        .prod    (in_prod),
        .abs_err (abs_err_w)
`ifdef MULT_ERR_BIAS_EN
        ,
        .neg     (neg_w)
`endif
    );

    // Stage 1: capture the error magnitude and operands of each accepted sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
            s1_a_reg     <= '0;
            s1_b_reg     <= '0;
            s1_abs_reg   <= '0;
`ifdef MULT_ERR_BIAS_EN
            s1_neg_reg   <= 1'b0;
`endif
        end else begin
            s1_valid_reg <= transfer;
            if (transfer) begin
                s1_a_reg   <= in_a;
                s1_b_reg   <= in_b;
                s1_abs_reg <= abs_err_w;
`ifdef MULT_ERR_BIAS_EN
                s1_neg_reg <= neg_w;
`endif
            end
        end
    end

    // Stage 2: accumulate; the strict compare keeps the earliest sample on ties.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_reg <= 1'b0;
            total_reg    <= '0;
            mismatch_reg <= '0;
            sum_abs_reg  <= '0;
            max_err_reg  <= '0;
            max_a_reg    <= '0;
            max_b_reg    <= '0;
        end else if (start_accept) begin
            s2_valid_reg <= 1'b0;
            total_reg    <= '0;
            mismatch_reg <= '0;
            sum_abs_reg  <= '0;
            max_err_reg  <= '0;
            max_a_reg    <= '0;
            max_b_reg    <= '0;
        end else begin
            s2_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                total_reg <= total_reg + CNT_W'(1);
                if (s1_abs_reg != '0)
                    mismatch_reg <= mismatch_reg + CNT_W'(1);
                sum_abs_reg <= SUM_W'(sat_add({{(64-SUM_W){1'b0}}, sum_abs_reg},
                                              {{(64-P_W){1'b0}}, s1_abs_reg},
                                              SUM_MAX));
                if (s1_abs_reg > max_err_reg) begin
                    max_err_reg <= s1_abs_reg;
                    max_a_reg   <= s1_a_reg;
                    max_b_reg   <= s1_b_reg;
                end
            end
        end
    end

`ifdef MULT_ERR_BIAS_EN
    localparam int W_S = ((P_W > SUM_W) ? P_W : SUM_W) + 2;
    localparam logic signed [W_S-1:0] S_MAX = {{(W_S-SUM_W){1'b0}}, {SUM_W{1'b1}}};
    localparam logic signed [W_S-1:0] S_MIN = ~S_MAX;

    logic signed [SUM_W:0]  sum_signed_reg;
    logic        [W_S-1:0]  err_mag;
    logic signed [W_S-1:0]  err_s, sum_s, sat_s;

    // Wide enough that the raw sum never overflows before clamping.
    always_comb begin
        err_mag = {{(W_S-P_W){1'b0}}, s1_abs_reg};
        err_s   = s1_neg_reg ? -$signed(err_mag) : $signed(err_mag);
        sum_s   = $signed({{(W_S-SUM_W-1){sum_signed_reg[SUM_W]}}, sum_signed_reg}) + err_s;
        sat_s   = sum_s;
        if (sum_s > S_MAX)
            sat_s = S_MAX;
        else if (sum_s < S_MIN)
            sat_s = S_MIN;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sum_signed_reg <= '0;
        else if (start_accept)
            sum_signed_reg <= '0;
        else if (s1_valid_reg)
            sum_signed_reg <= (SUM_W+1)'(sat_s);
    end

    assign sum_signed_err = sum_signed_reg;
`endif

    assign total_cnt    = total_reg;
    assign mismatch_cnt = mismatch_reg;
    assign sum_abs_err  = sum_abs_reg;
    assign max_abs_err  = max_err_reg;
    assign max_err_a    = max_a_reg;
    assign max_err_b    = max_b_reg;

endmodule
